// File: rtl/uart_param_if.sv
// uart_param_if: host-side bundle for uart_param (TX valid/ready, RX FIFO
// show-ahead port, error pulses and busy flags). The host takes the master
// modport and the UART takes the slave modport.
interface uart_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 rx_valid;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_ready;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;
    logic                 busy_tx;
    logic                 busy_rx;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err,
               rx_overrun, busy_tx, busy_rx
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err,
               rx_overrun, busy_tx, busy_rx
    );
endinterface

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with valid/ready TX, mid-bit
// sampling RX with framing-error detection and an RX FIFO with overrun pulse.
// Define UART_PARITY_EN to add an even parity bit after the data bits on both
// directions; without it there is no parity state and rx_parity_err stays 0.
module uart_param #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        nRst,
    uart_param_if.slave host,
    output logic        tx_out,
    input  logic        rx_in
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam int unsigned IDX_W = $clog2(RX_FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    // ---------------- TX ----------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_cnt_last;

    assign tx_cnt_last   = (tx_cnt_q == CNT_LAST);
    assign tx_out        = tx_out_q;
    assign host.tx_ready = (tx_state_q == TX_IDLE);
    assign host.busy_tx  = (tx_state_q != TX_IDLE);

    // TX next state: each state holds tx_out for one bit period
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (host.tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = host.tx_data;
                    tx_par_d   = ^host.tx_data;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_out_d   = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_last) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_out_d   = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_last) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_bit_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        tx_out_d   = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        tx_out_d   = 1'b1;
`endif
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_out_d   = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt_last) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = '0;
                    tx_out_d   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt_last) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX registers; reset drives the line idle high at once
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
            tx_par_q   <= tx_par_d;
        end
    end

    // ---------------- RX ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP, RX_BREAK
    } rx_state_e;

    rx_state_e            rx_state_q, rx_state_d;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_par_bad;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 rx_push;
    logic                 rx_cnt_last;

    assign rx_s          = sync_q[1];
    assign rx_cnt_last   = (rx_cnt_q == CNT_LAST);
`ifdef UART_PARITY_EN
    assign rx_par_bad    = (^rx_shift_q) ^ rx_par_q;
`else
    assign rx_par_bad    = 1'b0;
`endif
    assign host.busy_rx       = (rx_state_q != RX_IDLE);
    assign host.rx_frame_err  = ferr_q;
    assign host.rx_parity_err = perr_q;

    // RX next state: start validated at half bit, then one sample per bit period
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        rx_push    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_last) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_bit_d = '0;
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_last) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_last) begin
                    rx_cnt_d = '0;
                    perr_d   = rx_par_bad;
                    ferr_d   = !rx_s;
                    if (!rx_s) begin
                        rx_state_d = RX_BREAK;
                    end else begin
                        rx_state_d = RX_IDLE;
                        rx_push    = !rx_par_bad;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_BREAK: begin
                if (rx_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX registers and two-flop synchroniser (idle high)
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q     <= '1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx_in};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
    logic [IDX_W:0]       wr_q, rd_q;
    logic                 empty, full, pop, push_ok, ovr_q;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[IDX_W] != rd_q[IDX_W]) && (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    assign pop     = !empty && host.rx_ready;
    // a pop frees the head slot on the same edge, so a full FIFO still accepts
    assign push_ok = rx_push && (!full || pop);

    assign host.rx_valid   = !empty;
    assign host.rx_data    = empty ? '0 : mem_q[rd_q[IDX_W-1:0]];
    assign host.rx_overrun = ovr_q;

    // FIFO pointers and overrun pulse
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= rx_push && full && !pop;
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
        end
    end

    // FIFO storage; output is masked to zero while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[IDX_W-1:0]] <= rx_shift_q;
    end
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: randomized scoreboard bench for uart_param. Expected RX words
// are queued when stimulus is issued and a negedge monitor pops and compares
// them whenever the FIFO head is taken. Build with UART_PARITY_EN to run the
// 7-data-bit / 2-stop-bit parity configuration.
module tb_uart_param;
    localparam int unsigned CPB   = 16;
`ifdef UART_PARITY_EN
    localparam int unsigned DB    = 7;
    localparam int unsigned SB    = 2;
    localparam int unsigned PB    = 1;
    localparam logic [DB-1:0] B_WORD = 7'h07;
`else
    localparam int unsigned DB    = 8;
    localparam int unsigned SB    = 1;
    localparam int unsigned PB    = 0;
    localparam logic [DB-1:0] B_WORD = 8'hA5;
`endif
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NHEAD = 1 + DB + PB;
    localparam int unsigned NBITS = NHEAD + SB;
    localparam int unsigned FRAME = NBITS * CPB;
    localparam int unsigned LIMIT = 4 * FRAME;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    logic tx_out;
    logic rx_in;
    logic rx_drv = 1'b1;
    bit   use_loop = 1'b0;
    bit   sink_en = 1'b0;

    int checks = 0;
    int passed = 0;
    logic [DB-1:0] exp_q[$];
    int n_ferr = 0, n_perr = 0, n_ovr = 0;
    int e_ferr = 0, e_perr = 0, e_ovr = 0;
    time acc_t;

    uart_param_if #(.DATA_BITS(DB)) bus ();

    assign rx_in = use_loop ? tx_out : rx_drv;

    uart_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(DB),
        .STOP_BITS(SB),
        .RX_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .host(bus),
        .tx_out(tx_out),
        .rx_in(rx_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // reference frame: start 0, data LSB first, even parity, stop ones
    task automatic build_frame(input logic [DB-1:0] w, input bit flip_par, output bit lv[NBITS]);
        lv[0] = 1'b0;
        for (int unsigned i = 0; i < DB; i++) lv[1+i] = w[i];
        if (PB != 0) lv[1+DB] = (($countones(w) % 2) == 1) ^ flip_par;
        for (int unsigned s = 0; s < SB; s++) lv[NHEAD+s] = 1'b1;
    endtask

    task automatic tx_send(input logic [DB-1:0] w);
        int n = 0;
        while (!bus.tx_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) begin
            check("tx_ready_timeout", 32'(bus.tx_ready), 32'd1);
            return;
        end
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        @(posedge clk);
        acc_t = $time;
        if (use_loop) exp_q.push_back(w);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = DB'($urandom);
    endtask

    task automatic wait_tx_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle", 32'(bus.tx_ready), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_errs(input string name);
        check({name, "_frame_err"},  32'(n_ferr), 32'(e_ferr));
        check({name, "_parity_err"}, 32'(n_perr), 32'(e_perr));
        check({name, "_overrun"},    32'(n_ovr),  32'(e_ovr));
    endtask

    // drive one frame onto rx_in and record the outcome the FIFO must show
    task automatic drive_frame(input logic [DB-1:0] w, input bit stop_lvl,
                               input int unsigned stop_per, input bit flip_par);
        bit lv[NBITS];
        bit good;
        build_frame(w, flip_par, lv);
        @(posedge clk);
        #1;
        for (int unsigned b = 0; b < NHEAD; b++) begin
            rx_drv = lv[b];
            repeat (CPB) @(posedge clk);
            #1;
        end
        good = stop_lvl && !(PB != 0 && flip_par);
        if (!stop_lvl) e_ferr++;
        if (PB != 0 && flip_par) e_perr++;
        if (good) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else e_ovr++;
        end
        rx_drv = stop_lvl;
        repeat (stop_per * CPB) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    // monitor: error pulse counting and scoreboard compare on every pop
    always @(negedge clk) begin
        logic [DB-1:0] e;
        if (nRst) begin
            if (bus.rx_frame_err)  n_ferr++;
            if (bus.rx_parity_err) n_perr++;
            if (bus.rx_overrun)    n_ovr++;
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rx_unexpected: got %0h, expected no word", bus.rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_word", 32'(bus.rx_data), 32'(e));
                end
            end
        end
    end

    // random back-pressure on the RX FIFO
    initial begin
        bus.rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rx_ready = sink_en && ($urandom_range(3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        bit lv[NBITS];
        int bit_ok[NBITS];
        int ready_low;
        time t1;
        bit seen_busy;

        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_tx_out",    32'(tx_out),            32'd1);
        check("rst_tx_ready",  32'(bus.tx_ready),      32'd1);
        check("rst_busy_tx",   32'(bus.busy_tx),       32'd0);
        check("rst_busy_rx",   32'(bus.busy_rx),       32'd0);
        check("rst_rx_valid",  32'(bus.rx_valid),      32'd0);
        check("rst_rx_data",   32'(bus.rx_data),       32'd0);
        check("rst_frame_err", 32'(bus.rx_frame_err),  32'd0);
        check("rst_par_err",   32'(bus.rx_parity_err), 32'd0);
        check("rst_overrun",   32'(bus.rx_overrun),    32'd0);
        nRst = 1'b1;
        repeat (2) @(negedge clk);

        // TX waveform, tx_ready low time and back-to-back spacing
        build_frame(B_WORD, 1'b0, lv);
        for (int unsigned b = 0; b < NBITS; b++) bit_ok[b] = 0;
        ready_low = 0;
        tx_send(B_WORD);
        t1 = acc_t;
        for (int unsigned k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (tx_out === lv[k / CPB]) bit_ok[k / CPB]++;
            if (bus.tx_ready === 1'b0) ready_low++;
        end
        for (int unsigned b = 0; b < NBITS; b++)
            check($sformatf("tx_bit%0d_cycles", b), 32'(bit_ok[b]), 32'(CPB));
        check("tx_ready_low_cycles", 32'(ready_low), 32'(FRAME));
        @(negedge clk);
        check("tx_ready_return", 32'(bus.tx_ready), 32'd1);
        tx_send(DB'($urandom));
        check("tx_back_to_back", 32'((acc_t - t1) / 10), 32'(FRAME + 1));
        wait_tx_idle();

        // loopback: directed corner words then random ones
        use_loop = 1'b1;
        sink_en  = 1'b1;
        tx_send(DB'(8'h00));
        tx_send(DB'(8'hFF));
        tx_send(DB'(8'h3C));
        for (int i = 0; i < 10; i++) tx_send(DB'($urandom));
        wait_tx_idle();
        drain("loop_drain");
        check_errs("loop");
        use_loop = 1'b0;

        // short glitch must be rejected as a false start
        seen_busy = 1'b0;
        @(posedge clk);
        #1;
        rx_drv = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            if (bus.busy_rx) seen_busy = 1'b1;
        end
        check("glitch_seen_busy", 32'(seen_busy),    32'd1);
        check("glitch_busy_rx",   32'(bus.busy_rx),  32'd0);
        check("glitch_rx_valid",  32'(bus.rx_valid), 32'd0);
        check_errs("glitch");

        // framing error then a clean frame
        drive_frame(DB'(8'h55), 1'b0, 3, 1'b0);
        check("ferr_rx_valid", 32'(bus.rx_valid), 32'd0);
        drive_frame(DB'(8'h12), 1'b1, 1, 1'b0);
        drain("ferr_drain");
        check_errs("ferr");

        // overrun: fill the FIFO with no pops, one word too many
        sink_en = 1'b0;
        repeat (2) @(negedge clk);
        for (int v = 1; v <= 5; v++) drive_frame(DB'(v), 1'b1, 1, 1'b0);
        check_errs("ovr");
        @(negedge clk);
        check("ovr_rx_valid", 32'(bus.rx_valid), 32'd1);
        check("ovr_head",     32'(bus.rx_data),  32'(exp_q[0]));
        sink_en = 1'b1;
        drain("ovr_drain");

`ifdef UART_PARITY_EN
        // parity mismatch: pulse, no push
        drive_frame(DB'($urandom), 1'b1, 1, 1'b1);
        repeat (2) @(negedge clk);
        check("perr_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_errs("perr");
`endif

        // asynchronous reset mid-frame
        tx_send('0);
        repeat (CPB + 3) @(negedge clk);
        check("mid_frame_tx_low", 32'(tx_out), 32'd0);
        nRst = 1'b0;
        #1;
        check("async_rst_tx_out",   32'(tx_out),       32'd1);
        check("async_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("async_rst_busy_tx",  32'(bus.busy_tx),  32'd0);
        @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check_errs("final");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
